// File: rtl/rx_buffer_ctrl.sv
// RX FIFO controller: tracks occupancy, packs 1/2/4-byte host reads, runs flushes.
// Read latency N+1 cycles after rd_req in IDLE; errors answered in 1 cycle; RX bytes dropped when full or flushing.
module rx_buffer_ctrl #(
  parameter int DEPTH = 64,
  parameter int OCC_W = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             rx_byte_valid,
  input  logic [7:0]       rx_byte,
  input  logic             rx_packet_done,
  input  logic             rx_error,
  input  logic             flush,
  input  logic             rd_req,
  input  logic [1:0]       rd_size,
  output logic             rd_ack,
  output logic             rd_err,
  output logic [31:0]      rd_data,
  output logic [OCC_W-1:0] occupancy,
  output logic             rx_data_ready,
  output logic             overflow,
  output logic             fifo_w_enable,
  output logic [7:0]       fifo_w_data,
  output logic             fifo_r_enable,
  input  logic [7:0]       fifo_r_data,
  input  logic             fifo_full,
  input  logic             fifo_empty
);

  typedef enum logic [2:0] {IDLE, READ, ACK, ERR, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             rdy_q, rdy_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic             abort_q, abort_d;

  logic             wr;
  logic             pop;
  logic             flush_done;
  logic             abort_req;
  logic [OCC_W-1:0] need_n;
  logic [1:0]       last_n;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      occ_q     <= '0;
      rdy_q     <= 1'b0;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      rdy_q     <= rdy_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    rdy_d      = rdy_q;
    ovf_d      = ovf_q;
    rd_data_d  = rd_data_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    abort_d    = abort_q;
    pop        = 1'b0;
    flush_done = 1'b0;
    abort_req  = flush | rx_error;
    wr         = rx_byte_valid & ~fifo_full & (state_q != FLUSH);

    case (rd_size)
      2'd0:    begin need_n = OCC_W'(1); last_n = 2'd0; end
      2'd1:    begin need_n = OCC_W'(2); last_n = 2'd1; end
      2'd2:    begin need_n = OCC_W'(4); last_n = 2'd3; end
      default: begin need_n = '0;        last_n = 2'd0; end
    endcase

    if (rx_byte_valid && fifo_full && state_q != FLUSH) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (abort_req) begin
          state_d = FLUSH;
        end else if (rd_req) begin
          rd_data_d = '0;
          if (rd_size == 2'd3 || occ_q < need_n) begin
            state_d = ERR;
          end else begin
            state_d = READ;
            cnt_d   = '0;
            last_d  = last_n;
          end
        end
      end
      READ: begin
        // The guard on fifo_empty never fires once occupancy was checked; it only keeps the FIFO safe.
        pop = ~fifo_empty;
        if (abort_req) begin
          state_d = FLUSH;
          abort_d = 1'b1;
        end else if (pop) begin
          case (cnt_q)
            2'd0:    rd_data_d[7:0]   = fifo_r_data;
            2'd1:    rd_data_d[15:8]  = fifo_r_data;
            2'd2:    rd_data_d[23:16] = fifo_r_data;
            default: rd_data_d[31:24] = fifo_r_data;
          endcase
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == last_q) begin
            state_d = ACK;
          end
        end
      end
      ACK, ERR: begin
        state_d = abort_req ? FLUSH : IDLE;
      end
      FLUSH: begin
        pop = ~fifo_empty;
        if (fifo_empty) begin
          flush_done = 1'b1;
          ovf_d      = 1'b0;
          abort_d    = 1'b0;
          if (abort_q) begin
            state_d   = ERR;
            rd_data_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr && !pop && occ_q != OCC_W'(DEPTH)) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop && !wr && occ_q != '0) begin
      occ_d = occ_q - OCC_W'(1);
    end
    if (flush_done) begin
      occ_d = '0;
    end

    // Emptying wins over a coincident end-of-packet: nothing is left to read.
    if (occ_d == '0) begin
      rdy_d = 1'b0;
    end else if (rx_packet_done && (occ_q != '0 || wr)) begin
      rdy_d = 1'b1;
    end
  end

  assign fifo_w_enable = wr;
  assign fifo_w_data   = rx_byte;
  assign fifo_r_enable = pop;
  assign rd_ack        = (state_q == ACK) || (state_q == ERR);
  assign rd_err        = (state_q == ERR);
  assign rd_data       = rd_data_q;
  assign occupancy     = occ_q;
  assign rx_data_ready = rdy_q;
  assign overflow      = ovf_q;

endmodule
